// File: rtl/sw_output_arb.sv
// sw_output_arb: per-output-port round-robin switch allocator that owns the downstream per-VC credit counters.
// Optional packet locking with SW_PKT_LOCK_EN.                                           Rev 1.0
`default_nettype none

module sw_output_arb #(
   parameter  int NUM_IN    = 4,
   parameter  int NUM_VCS   = 2,
   parameter  int BUF_DEPTH = 4,
   localparam int REQ_N     = NUM_IN * NUM_VCS
) (
   input  logic                                 clk,
   input  logic                                 arst_n,
   input  logic [REQ_N-1:0]                     req_i,
   input  logic [REQ_N*$clog2(NUM_VCS)-1:0]     req_ovc_i,
   input  logic [REQ_N-1:0]                     req_tail_i,
   input  logic [NUM_VCS-1:0]                   credit_in_i,
   output logic [REQ_N-1:0]                     grant_o,
   output logic                                 grant_valid_o,
   output logic [$clog2(NUM_VCS)-1:0]           grant_ovc_o,
   output logic [$clog2(NUM_IN)-1:0]            xbar_sel_o,
   output logic [NUM_VCS-1:0]                   credit_avail_o
);

   localparam int VCW     = $clog2(NUM_VCS);
   localparam int SELW    = $clog2(NUM_IN);
   localparam int PTRW    = $clog2(REQ_N);
   localparam int CNTW    = $clog2(BUF_DEPTH + 1);
   localparam int NVC_PAD = 1 << VCW;

   localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(BUF_DEPTH);
   localparam logic [PTRW:0]   REQ_N_EXT = (PTRW+1)'(REQ_N);
   localparam logic [PTRW-1:0] LAST_R    = PTRW'(REQ_N - 1);

   logic [NUM_VCS-1:0][CNTW-1:0] cnt_q, cnt_d;
   logic [PTRW-1:0]              ptr_q, ptr_d;
   logic [REQ_N-1:0]             grant_q, grant_d;
   logic                         gvalid_q;
   logic [VCW-1:0]               govc_q, govc_d;
   logic [SELW-1:0]              xsel_q, xsel_d;

   logic [NVC_PAD-1:0]           w_cnt_nz;
   logic [REQ_N-1:0]             w_elig;
   logic                         w_win_valid;
   logic [PTRW-1:0]              w_winner;
   logic [PTRW:0]                w_scan;
   logic [VCW-1:0]               w_win_ovc;
   logic [SELW-1:0]              w_win_sel;
   logic [NUM_VCS-1:0]           w_dec;
   logic                         w_ptr_adv;

`ifdef SW_PKT_LOCK_EN
   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [PTRW-1:0] lock_q, lock_d;
   logic            w_win_tail;

   assign w_win_tail = req_tail_i[w_winner];
`else
   logic unused_tail;

   assign unused_tail = ^req_tail_i;
`endif

   // Pad the non-zero vector to a power of two so any req_ovc encoding indexes safely.
   generate
      for (genvar v = 0; v < NVC_PAD; v++) begin : g_cnt_nz
         if (v < NUM_VCS) begin : g_real
            assign w_cnt_nz[v] = |cnt_q[v];
         end else begin : g_pad
            assign w_cnt_nz[v] = 1'b0;
         end
      end
   endgenerate

   assign credit_avail_o = w_cnt_nz[NUM_VCS-1:0];

   always_comb begin
      w_elig = '0;
      for (int r = 0; r < REQ_N; r++) begin
         w_elig[r] = req_i[r] & w_cnt_nz[req_ovc_i[r*VCW +: VCW]];
      end
`ifdef SW_PKT_LOCK_EN
      if (state_q == ST_LOCKED) begin
         w_elig = w_elig & (REQ_N'(1) << lock_q);
      end
`endif
   end

   // Circular priority chain starting at ptr_q.
   always_comb begin
      w_win_valid = 1'b0;
      w_winner    = '0;
      w_scan      = '0;
      for (int i = 0; i < REQ_N; i++) begin
         w_scan = {1'b0, ptr_q} + (PTRW+1)'(i);
         if (w_scan >= REQ_N_EXT) begin
            w_scan = w_scan - REQ_N_EXT;
         end
         if (!w_win_valid && w_elig[w_scan[PTRW-1:0]]) begin
            w_win_valid = 1'b1;
            w_winner    = w_scan[PTRW-1:0];
         end
      end
   end

   always_comb begin
      w_win_ovc = '0;
      w_win_sel = '0;
      for (int r = 0; r < REQ_N; r++) begin
         if (w_winner == PTRW'(r)) begin
            w_win_ovc = req_ovc_i[r*VCW +: VCW];
            w_win_sel = SELW'(r / NUM_VCS);
         end
      end
   end

   always_comb begin
      w_dec = '0;
      for (int v = 0; v < NUM_VCS; v++) begin
         w_dec[v] = w_win_valid && (w_win_ovc == VCW'(v));
      end
   end

   // A simultaneous decrement and credit return cancel; returns into a full counter saturate.
   always_comb begin
      cnt_d = cnt_q;
      for (int v = 0; v < NUM_VCS; v++) begin
         if (w_dec[v] && !credit_in_i[v]) begin
            cnt_d[v] = cnt_q[v] - CNTW'(1);
         end else if (!w_dec[v] && credit_in_i[v] && (cnt_q[v] != CNT_MAX)) begin
            cnt_d[v] = cnt_q[v] + CNTW'(1);
         end
      end
   end

`ifdef SW_PKT_LOCK_EN
   assign w_ptr_adv = w_win_valid & w_win_tail;
`else
   assign w_ptr_adv = w_win_valid;
`endif

   always_comb begin
      ptr_d = ptr_q;
      if (w_ptr_adv) begin
         ptr_d = (w_winner == LAST_R) ? '0 : w_winner + PTRW'(1);
      end
   end

   always_comb begin
      grant_d = '0;
      if (w_win_valid) begin
         grant_d[w_winner] = 1'b1;
      end
      govc_d = w_win_valid ? w_win_ovc : '0;
      xsel_d = w_win_valid ? w_win_sel : '0;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt_q    <= {NUM_VCS{CNT_MAX}};
         ptr_q    <= '0;
         grant_q  <= '0;
         gvalid_q <= 1'b0;
         govc_q   <= '0;
         xsel_q   <= '0;
      end else begin
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         gvalid_q <= w_win_valid;
         govc_q   <= govc_d;
         xsel_q   <= xsel_d;
      end
   end

`ifdef SW_PKT_LOCK_EN
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= ST_IDLE;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
      end
   end

   // A non-tail grant opens a packet; the same requester keeps the port until its tail.
   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      case (state_q)
         ST_IDLE: begin
            if (w_win_valid && !w_win_tail) begin
               state_d = ST_LOCKED;
               lock_d  = w_winner;
            end
         end
         ST_LOCKED: begin
            if (w_win_valid && w_win_tail) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end
`endif

   assign grant_o       = grant_q;
   assign grant_valid_o = gvalid_q;
   assign grant_ovc_o   = govc_q;
   assign xbar_sel_o    = xsel_q;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (arst_n) begin
         assert ($onehot0(grant_q)) else $error("grant is not one-hot");
         if (w_win_valid) begin
            assert (w_cnt_nz[w_win_ovc]) else $error("grant issued to VC with zero credits");
         end
         for (int v = 0; v < NUM_VCS; v++) begin
            if (credit_in_i[v] && !w_dec[v] && (cnt_q[v] == CNT_MAX)) begin
               $error("CREDIT OVERFLOW");
            end
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sw_output_arb.sv
// tb_sw_output_arb: vector table with a scoreboard queue, plus hand-written reset and credit-refill sequences.
`default_nettype none

module tb_sw_output_arb;

   logic       clk = 1'b0;
   logic       arst_n;
   logic [7:0] req;
   logic [7:0] req_ovc;
   logic [7:0] req_tail;
   logic [1:0] credit_in;
   logic [7:0] grant;
   logic       grant_valid;
   logic       grant_ovc;
   logic [1:0] xbar_sel;
   logic [1:0] credit_avail;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic [7:0] ovc;
      logic [7:0] tail;
      logic [1:0] cred;
      logic [7:0] egnt;
      logic [1:0] exsel;
      logic       eovc;
      logic [1:0] ecav;
   } vec_t;

   typedef struct {
      logic [7:0] egnt;
      logic [1:0] exsel;
      logic       eovc;
      logic [1:0] ecav;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   sw_output_arb #(.NUM_IN(4), .NUM_VCS(2), .BUF_DEPTH(4)) dut (
      .clk            (clk),
      .arst_n         (arst_n),
      .req_i          (req),
      .req_ovc_i      (req_ovc),
      .req_tail_i     (req_tail),
      .credit_in_i    (credit_in),
      .grant_o        (grant),
      .grant_valid_o  (grant_valid),
      .grant_ovc_o    (grant_ovc),
      .xbar_sel_o     (xbar_sel),
      .credit_avail_o (credit_avail)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic rst, input logic [7:0] r, input logic [7:0] o, input logic [7:0] t,
                      input logic [1:0] c, input logic [7:0] g, input logic [1:0] x, input logic go,
                      input logic [1:0] ca);
      vec_t v;
      v.rst = rst; v.req = r; v.ovc = o; v.tail = t; v.cred = c;
      v.egnt = g; v.exsel = x; v.eovc = go; v.ecav = ca;
      vecs.push_back(v);
   endtask

   // Scoreboard consumer: one expected record per driven cycle, compared after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("grant",        grant,              e.egnt);
            chk("grant_valid",  8'(grant_valid),    8'(e.egnt != 8'h00));
            chk("xbar_sel",     8'(xbar_sel),       8'(e.exsel));
            chk("grant_ovc",    8'(grant_ovc),      8'(e.eovc));
            chk("credit_avail", 8'(credit_avail),   8'(e.ecav));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   cnt;
      logic got;

      arst_n = 1'b0; req = '0; req_ovc = '0; req_tail = '0; credit_in = '0;

      // Drain VC0 to zero, then refill one credit.
      add(1, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 2'd0, 1'b0, 2'b11);
      add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h01, 2'd0, 1'b0, 2'b11);
      add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h01, 2'd0, 1'b0, 2'b11);
      add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h01, 2'd0, 1'b0, 2'b11);
      add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h01, 2'd0, 1'b0, 2'b10);
      add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h00, 2'd0, 1'b0, 2'b10);
      add(0, 8'h01, 8'h00, 8'h00, 2'b01, 8'h00, 2'd0, 1'b0, 2'b11);
      add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h01, 2'd0, 1'b0, 2'b10);
      add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h00, 2'd0, 1'b0, 2'b10);
      // Round-robin over requesters 0,3,5 with credits returned as they are used.
      add(1, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 2'd0, 1'b0, 2'b11);
      add(0, 8'h29, 8'h08, 8'h00, 2'b01, 8'h01, 2'd0, 1'b0, 2'b11);
      add(0, 8'h29, 8'h08, 8'h00, 2'b10, 8'h08, 2'd1, 1'b1, 2'b11);
      add(0, 8'h29, 8'h08, 8'h00, 2'b01, 8'h20, 2'd2, 1'b0, 2'b11);
      add(0, 8'h29, 8'h08, 8'h00, 2'b01, 8'h01, 2'd0, 1'b0, 2'b11);
      add(0, 8'h29, 8'h08, 8'h00, 2'b10, 8'h08, 2'd1, 1'b1, 2'b11);
      add(0, 8'h29, 8'h08, 8'h00, 2'b01, 8'h20, 2'd2, 1'b0, 2'b11);
      // cnt0=1 with coincident credit return, then VC0 empty while VC1 still competes.
      add(1, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 2'd0, 1'b0, 2'b11);
      add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h01, 2'd0, 1'b0, 2'b11);
      add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h01, 2'd0, 1'b0, 2'b11);
      add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h01, 2'd0, 1'b0, 2'b11);
      add(0, 8'h01, 8'h00, 8'h00, 2'b01, 8'h01, 2'd0, 1'b0, 2'b11);
      add(0, 8'h01, 8'h00, 8'h00, 2'b00, 8'h01, 2'd0, 1'b0, 2'b10);
      add(0, 8'h05, 8'h04, 8'h00, 2'b00, 8'h04, 2'd1, 1'b1, 2'b10);
      add(0, 8'h00, 8'h00, 8'h00, 2'b11, 8'h00, 2'd0, 1'b0, 2'b11);
      // Three-flit packet on requester 1 against single-flit requester 2.
      add(1, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 2'd0, 1'b0, 2'b11);
      add(0, 8'h06, 8'h00, 8'h04, 2'b00, 8'h02, 2'd0, 1'b0, 2'b11);
`ifdef SW_PKT_LOCK_EN
      add(0, 8'h06, 8'h00, 8'h04, 2'b00, 8'h02, 2'd0, 1'b0, 2'b11);
`else
      add(0, 8'h06, 8'h00, 8'h04, 2'b00, 8'h04, 2'd1, 1'b0, 2'b11);
`endif
      add(0, 8'h06, 8'h00, 8'h06, 2'b00, 8'h02, 2'd0, 1'b0, 2'b11);
      add(0, 8'h04, 8'h00, 8'h04, 2'b00, 8'h04, 2'd1, 1'b0, 2'b10);

      foreach (vecs[i]) begin
         @(negedge clk);
         arst_n    = !vecs[i].rst;
         req       = vecs[i].req;
         req_ovc   = vecs[i].ovc;
         req_tail  = vecs[i].tail;
         credit_in = vecs[i].cred;
         e.egnt = vecs[i].egnt; e.exsel = vecs[i].exsel; e.eovc = vecs[i].eovc; e.ecav = vecs[i].ecav;
         sb.push_back(e);
      end
      @(negedge clk);
      req = '0; req_ovc = '0; req_tail = '0; credit_in = '0;
      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 8'(sb.size()), 8'd0);

      // Asynchronous reset mid-cycle while VC0 is empty and a grant is showing.
      req = 8'h80; req_ovc = 8'h80;
      @(posedge clk); #1;
      chk("pre_reset_grant", grant,    8'h80);
      chk("pre_reset_xsel",  8'(xbar_sel), 8'd3);
      req = '0;
      #2 arst_n = 1'b0;
      #1;
      chk("async_rst_grant", grant,              8'h00);
      chk("async_rst_valid", 8'(grant_valid),    8'd0);
      chk("async_rst_xsel",  8'(xbar_sel),       8'd0);
      chk("async_rst_cav",   8'(credit_avail),   8'h3);
      @(negedge clk);
      arst_n = 1'b1;

      // Drain VC1 with requester 7 held, then one credit buys exactly one more grant.
      @(negedge clk);
      req = 8'h80; req_ovc = 8'h80;
      cnt = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (grant_valid) cnt++;
      end
      chk("drain_count", 8'(cnt), 8'd4);
      chk("drain_cav",   8'(credit_avail), 8'h1);
      @(negedge clk);
      credit_in = 2'b10;
      @(negedge clk);
      credit_in = 2'b00;
      got = 1'b0;
      for (int k = 0; k < 5 && !got; k++) begin
         @(posedge clk); #1;
         if (grant_valid) got = 1'b1;
      end
      chk("refill_grant", 8'(got), 8'd1);
      cnt = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (grant_valid) cnt++;
      end
      chk("refill_only_one", 8'(cnt), 8'd0);
      @(negedge clk);
      req = '0; req_ovc = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sw_output_arb.md
Name: sw_output_arb

Overview:
- Per-output-port switch allocator stage. Sits after VC allocation and in front of the crossbar.
- Each input VC that holds an allocated output VC requests this output port's crossbar slot. The block picks one winner per cycle using round-robin.
- A request is eligible only if downstream buffer credits exist for its output VC. The block owns the per-output-VC credit counters.

Parameters:
- NUM_IN, 4, number of input ports competing (router ports minus the local output).
- NUM_VCS, 2, VCs per port; minimum 2.
- BUF_DEPTH, 4, downstream buffer slots per VC; this is also the credit counter reset value.
- REQ_N, derived NUM_IN*NUM_VCS, flat requester count. Requester index r = p*NUM_VCS+v.

Ports:
- clk  input  1  clock.
- arst_n  input  1  reset, asynchronous, active-low.
- req  input  REQ_N  requester r has a flit ready for this output.
- req_ovc  input  REQ_N*$clog2(NUM_VCS)  allocated output VC of requester r; field r occupies bits [r*W +: W].
- req_tail  input  REQ_N  flit at the head of requester r is a tail flit.
- credit_in  input  NUM_VCS  one-cycle credit return pulse per output VC from downstream.
- grant  output  REQ_N  registered one-hot grant; all zero when idle.
- grant_valid  output  1  OR of grant.
- grant_ovc  output  $clog2(NUM_VCS)  output VC of the granted flit.
- xbar_sel  output  $clog2(NUM_IN)  crossbar input select, equal to the granted r / NUM_VCS.
- credit_avail  output  NUM_VCS  credit counter for VC v is non-zero.

Behaviour:
- Reset:
  - grant=0, grant_valid=0, grant_ovc=0, xbar_sel=0.
  - Credit counters = BUF_DEPTH, so credit_avail = all ones.
  - Round-robin pointer = 0.
- Counter width: $clog2(BUF_DEPTH+1).
- Eligibility (combinational): elig[r] = req[r] & (cnt[req_ovc[r]] != 0).
- Arbitration: the first eligible r scanning ptr, ptr+1, ..., REQ_N-1, 0, ..., ptr-1 (circular priority chain). The winner is registered into grant on the next clk edge. Latency from req to grant is 1 cycle.
- Pointer update: on any grant, ptr <= (winner+1) mod REQ_N. With no grant, ptr holds.
- Credit accounting, per VC, in the cycle the grant register is loaded:
  - cnt <= cnt - dec + inc.
  - dec = 1 if the winner's req_ovc equals this VC.
  - inc = credit_in[v].
  - Simultaneous dec and inc leave the count unchanged.
  - Eligibility uses the pre-update count. A VC with cnt=1 therefore cannot be granted twice in consecutive cycles: the second cycle sees 0.
- Boundaries:
  - cnt=0: requesters for that VC are masked; other VCs still compete.
  - cnt=BUF_DEPTH with credit_in and no dec: counter saturates at BUF_DEPTH. Under `ifndef SYNTHESIS, $error "CREDIT OVERFLOW".
  - Requester drops req after being granted: no effect; grants are single-cycle pulses.
  - Reset mid-operation: everything returns to its reset values immediately (asynchronous); in-flight credits are lost by design.
- Assertions under `ifndef SYNTHESIS:
  - grant is one-hot or zero.
  - No grant is issued to a VC whose count is 0.

Optional Feature:
- Macro: SW_PKT_LOCK_EN.
- Defined: a 2-state FSM, IDLE and LOCKED, with a lock_r register.
  - IDLE: normal round-robin. A grant with req_tail=0 moves the FSM to LOCKED with lock_r=winner.
  - LOCKED: only lock_r is eligible, still subject to credits. A grant to lock_r with req_tail=1 returns the FSM to IDLE.
  - The pointer is updated only on the grant that leaves or bypasses LOCKED, i.e. on a tail grant.
  - Single-flit packets (head=tail) never lock.
  - Reset puts the FSM in IDLE.
- Undefined: flit-level interleaving. req_tail is ignored and there is no FSM.

Test Plan:
- Reset, then no requests -> grant=0, grant_valid=0, credit_avail=2'b11, all counters 4.
- req[0]=1 held, req_ovc=0, no credit_in -> grants at cycles 1-4; cnt0 reaches 0, credit_avail[0]=0, no further grant; one credit_in[0] pulse -> exactly one more grant.
- req[0], req[3] and req[5] held, ample credits -> grant order 0,3,5,0,3,5; xbar_sel sequence 0,1,2,0,1,2.
- cnt0=1, grant to VC0 issued in the same cycle as credit_in[0]=1 -> cnt0 stays 1; in the next cycle the requester is eligible again.
- cnt1=4 with credit_in[1]=1 and no grant -> cnt1 stays 4 and the overflow error fires (simulation only).
- With SW_PKT_LOCK_EN, req[1] sending a 3-flit packet (tail on the 3rd flit) and req[2] held -> grants 1,1,1,2. Without the macro -> 1,2,1,2,...
